// File: rtl/cpu_cache_controller.sv
// CPU-side cache controller: lookup, bus arbitration, line write-back and fill.
// Define CPU_CACHE_CONTROLLER_UPGRADE_EN to upgrade SHARED write hits via busInvalidate.
module cpu_cache_controller #(
    parameter int TAG_WIDTH    = 6,
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 2,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] cpuAddress,
    input  logic [DATA_WIDTH-1:0]                       cpuDataIn,
    input  logic                                        cpuRead,
    input  logic                                        cpuWrite,
    output logic [DATA_WIDTH-1:0]                       cpuDataOut,
    output logic                                        cpuFunctionComplete,
    output logic [TAG_WIDTH-1:0]                        cacheTag,
    output logic [INDEX_WIDTH-1:0]                      cacheIndex,
    output logic [OFFSET_WIDTH-1:0]                     cacheOffset,
    output logic [DATA_WIDTH-1:0]                       cacheDataOut,
    output logic [1:0]                                  cacheStateOut,
    output logic                                        cacheWriteTag,
    output logic                                        cacheWriteData,
    output logic                                        cacheWriteState,
    output logic                                        accessEnable,
    input  logic                                        cacheHit,
    input  logic [TAG_WIDTH-1:0]                        cacheTagIn,
    input  logic [DATA_WIDTH-1:0]                       cacheDataIn,
    input  logic [1:0]                                  cacheStateIn,
    output logic                                        busRequest,
    input  logic                                        busGrant,
    output logic                                        busRead,
    output logic                                        busReadExclusive,
    output logic                                        busWrite,
    output logic                                        busInvalidate,
    output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] busAddress,
    output logic [DATA_WIDTH-1:0]                       busDataOut,
    input  logic [DATA_WIDTH-1:0]                       busDataIn,
    input  logic                                        busAck
);

    localparam logic [1:0] INVALID  = 2'd0;
    localparam logic [1:0] SHARED   = 2'd1;
    localparam logic [1:0] MODIFIED = 2'd2;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, ARBITRATE, WRITEBACK, FILL, COMPLETE
    } ctrlState;

    ctrlState state, nextState;

    logic [TAG_WIDTH-1:0]    reqTag;
    logic [INDEX_WIDTH-1:0]  reqIndex;
    logic [OFFSET_WIDTH-1:0] reqOffset;
    logic [DATA_WIDTH-1:0]   reqData;
    logic                    reqWrite;
    logic [OFFSET_WIDTH-1:0] wordCount;

    logic lastWord, wordDone, hitReady, upgrade;

    assign lastWord = &wordCount;
    assign wordDone = busAck && (state == WRITEBACK || state == FILL);
    assign hitReady = cacheHit && (!reqWrite || cacheStateIn == MODIFIED);

`ifdef CPU_CACHE_CONTROLLER_UPGRADE_EN
    // Only a SHARED write hit can still be hitting once we are arbitrating.
    assign upgrade = cacheHit && reqWrite;
`else
    assign upgrade = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reqTag     <= '0;
            reqIndex   <= '0;
            reqOffset  <= '0;
            reqData    <= '0;
            reqWrite   <= 1'b0;
            wordCount  <= '0;
            cpuDataOut <= '0;
        end else begin
            if (state == IDLE && (cpuRead || cpuWrite)) begin
                {reqTag, reqIndex, reqOffset} <= cpuAddress;
                reqData  <= cpuDataIn;
                reqWrite <= cpuWrite;
            end
            // Wraps to zero on the last word, ready for the next burst.
            if (wordDone) wordCount <= wordCount + 1'b1;
            if (state == LOOKUP && hitReady) cpuDataOut <= cacheDataIn;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:
                if (cpuRead || cpuWrite) nextState = LOOKUP;
            LOOKUP:
                nextState = hitReady ? COMPLETE : ARBITRATE;
            ARBITRATE:
                if (busGrant) begin
                    if (upgrade)
                        nextState = busAck ? COMPLETE : ARBITRATE;
                    else if (!cacheHit && cacheStateIn == MODIFIED)
                        nextState = WRITEBACK;
                    else
                        nextState = FILL;
                end
            WRITEBACK:
                if (wordDone && lastWord) nextState = FILL;
            FILL:
                if (wordDone && lastWord) nextState = LOOKUP;
            COMPLETE:
                nextState = IDLE;
            default:
                nextState = IDLE;
        endcase
    end

    always_comb begin
        cpuFunctionComplete = 1'b0;
        cacheTag            = '0;
        cacheIndex          = '0;
        cacheOffset         = '0;
        cacheDataOut        = '0;
        cacheStateOut       = INVALID;
        cacheWriteTag       = 1'b0;
        cacheWriteData      = 1'b0;
        cacheWriteState     = 1'b0;
        accessEnable        = 1'b0;
        busRequest          = 1'b0;
        busRead             = 1'b0;
        busReadExclusive    = 1'b0;
        busWrite            = 1'b0;
        busInvalidate       = 1'b0;
        busAddress          = '0;
        busDataOut          = '0;
        if (state != IDLE) begin
            cacheTag    = reqTag;
            cacheIndex  = reqIndex;
            cacheOffset = reqOffset;
        end
        unique case (state)
            LOOKUP:
                if (hitReady) begin
                    accessEnable = 1'b1;
                    if (reqWrite) begin
                        cacheWriteData  = 1'b1;
                        cacheWriteState = 1'b1;
                        cacheStateOut   = MODIFIED;
                        cacheDataOut    = reqData;
                    end
                end
            ARBITRATE: begin
                busRequest = 1'b1;
                if (busGrant && upgrade) begin
                    busInvalidate = 1'b1;
                    busAddress    = {reqTag, reqIndex, {OFFSET_WIDTH{1'b0}}};
                    if (busAck) begin
                        cacheWriteData  = 1'b1;
                        cacheWriteState = 1'b1;
                        cacheStateOut   = MODIFIED;
                        cacheDataOut    = reqData;
                    end
                end
            end
            WRITEBACK: begin
                busRequest  = 1'b1;
                busWrite    = 1'b1;
                cacheOffset = wordCount;
                busAddress  = {cacheTagIn, reqIndex, wordCount};
                busDataOut  = cacheDataIn;
            end
            FILL: begin
                busRequest       = 1'b1;
                busRead          = !reqWrite;
                busReadExclusive = reqWrite;
                cacheOffset      = wordCount;
                busAddress       = {reqTag, reqIndex, wordCount};
                if (busAck) begin
                    cacheWriteData = 1'b1;
                    cacheDataOut   = busDataIn;
                    if (lastWord) begin
                        cacheWriteTag   = 1'b1;
                        cacheWriteState = 1'b1;
                        cacheStateOut   = reqWrite ? MODIFIED : SHARED;
                    end
                end
            end
            COMPLETE:
                cpuFunctionComplete = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_cache_controller.sv
// Directed bench for cpu_cache_controller with a one-line cache model and a bus responder.
// Fill data is 0xA000 | word address; victim data is preloaded per test.
module tb_cpu_cache_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] cpuAddress = '0;
    logic [15:0] cpuDataIn = '0;
    logic        cpuRead = 1'b0;
    logic        cpuWrite = 1'b0;
    logic [15:0] cpuDataOut;
    logic        cpuFunctionComplete;
    logic [5:0]  cacheTag;
    logic [3:0]  cacheIndex;
    logic [1:0]  cacheOffset;
    logic [15:0] cacheDataOut;
    logic [1:0]  cacheStateOut;
    logic        cacheWriteTag, cacheWriteData, cacheWriteState, accessEnable;
    logic        cacheHit;
    logic [5:0]  cacheTagIn;
    logic [15:0] cacheDataIn;
    logic [1:0]  cacheStateIn;
    logic        busRequest;
    logic        busGrant = 1'b0;
    logic        busRead, busReadExclusive, busWrite, busInvalidate;
    logic [11:0] busAddress;
    logic [15:0] busDataOut;
    logic [15:0] busDataIn = '0;
    logic        busAck = 1'b0;

    logic [5:0]  lineTag = '0;
    logic [1:0]  lineState = '0;
    logic [15:0] lineData [4];

    assign cacheHit     = (lineState != 2'd0) && (lineTag == cacheTag);
    assign cacheTagIn   = lineTag;
    assign cacheStateIn = lineState;
    assign cacheDataIn  = lineData[cacheOffset];

    int passCnt = 0;
    int totalCnt = 0;

    int cycles, accessCnt, reqCycles, wbCnt, rdCnt, rdxCnt, invCnt, tagWrCnt;
    bit doneSeen, aborted;
    logic [1:0]  tagWrState, stateWrVal;
    logic [11:0] wbAddr [8];
    logic [15:0] wbData [8];
    logic [11:0] fillAddr [8];

    cpu_cache_controller dut (
        .clock(clock), .reset(reset),
        .cpuAddress(cpuAddress), .cpuDataIn(cpuDataIn),
        .cpuRead(cpuRead), .cpuWrite(cpuWrite),
        .cpuDataOut(cpuDataOut), .cpuFunctionComplete(cpuFunctionComplete),
        .cacheTag(cacheTag), .cacheIndex(cacheIndex), .cacheOffset(cacheOffset),
        .cacheDataOut(cacheDataOut), .cacheStateOut(cacheStateOut),
        .cacheWriteTag(cacheWriteTag), .cacheWriteData(cacheWriteData),
        .cacheWriteState(cacheWriteState), .accessEnable(accessEnable),
        .cacheHit(cacheHit), .cacheTagIn(cacheTagIn),
        .cacheDataIn(cacheDataIn), .cacheStateIn(cacheStateIn),
        .busRequest(busRequest), .busGrant(busGrant),
        .busRead(busRead), .busReadExclusive(busReadExclusive),
        .busWrite(busWrite), .busInvalidate(busInvalidate),
        .busAddress(busAddress), .busDataOut(busDataOut),
        .busDataIn(busDataIn), .busAck(busAck)
    );

    always #5 clock = ~clock;

    function automatic logic [83:0] outBits();
        return {cpuDataOut, cpuFunctionComplete, cacheTag, cacheIndex,
                cacheOffset, cacheDataOut, cacheStateOut, cacheWriteTag,
                cacheWriteData, cacheWriteState, accessEnable, busRequest,
                busRead, busReadExclusive, busWrite, busInvalidate,
                busAddress, busDataOut};
    endfunction

    task automatic preload(input logic [5:0] tag, input logic [1:0] st,
                           input logic [15:0] base);
        lineTag   = tag;
        lineState = st;
        for (int i = 0; i < 4; i++) lineData[i] = base + 16'(i);
    endtask

    // Runs one CPU request, acting as cache array and bus responder.
    task automatic doAccess(input bit wr, input logic [11:0] addr,
                            input logic [15:0] data, input int stall,
                            input bit stray, input int abortAt);
        bit pD, pT, pS, busy;
        logic [1:0]  pOff, pSt;
        logic [15:0] pData;
        logic [5:0]  pTag;
        int stallLeft;
        cycles = 0; accessCnt = 0; reqCycles = 0; wbCnt = 0; rdCnt = 0;
        rdxCnt = 0; invCnt = 0; tagWrCnt = 0; doneSeen = 0; aborted = 0;
        tagWrState = '0; stateWrVal = '0;
        pD = 0; pT = 0; pS = 0; pOff = '0; pSt = '0; pData = '0; pTag = '0;
        stallLeft = stall;
        @(negedge clock);
        cpuAddress = addr; cpuDataIn = data;
        cpuRead = !wr; cpuWrite = wr; busAck = stray;
        for (int c = 1; c <= 60 && !doneSeen && !aborted; c++) begin
            @(negedge clock);
            if (pD) lineData[pOff] = pData;
            if (pT) lineTag = pTag;
            if (pS) lineState = pSt;
            pD = 0; pT = 0; pS = 0;
            cycles = c;
            busGrant = busRequest;
            #1;
            busy = busWrite | busRead | busReadExclusive | busInvalidate;
            if (busy && stallLeft > 0) begin
                stallLeft--;
                busAck = stray;
            end else begin
                busAck = busy | stray;
            end
            busDataIn = 16'hA000 | {4'h0, busAddress};
            #1;
            if (busRequest) reqCycles++;
            if (accessEnable) accessCnt++;
            if (busAck && busWrite && wbCnt < 8) begin
                wbAddr[wbCnt] = busAddress;
                wbData[wbCnt] = busDataOut;
                wbCnt++;
            end
            if (busAck && busRead && rdCnt < 8) begin
                fillAddr[rdCnt] = busAddress;
                rdCnt++;
            end
            if (busAck && busReadExclusive) rdxCnt++;
            if (busAck && busInvalidate) invCnt++;
            if (cacheWriteTag) begin
                tagWrCnt++;
                tagWrState = cacheStateOut;
            end
            if (cacheWriteState) stateWrVal = cacheStateOut;
            if (abortAt >= 0 && busAck && busRead && rdCnt - 1 == abortAt) begin
                reset = 1'b0;
                aborted = 1;
            end else begin
                pD = cacheWriteData;  pOff = cacheOffset; pData = cacheDataOut;
                pT = cacheWriteTag;   pTag = cacheTag;
                pS = cacheWriteState; pSt = cacheStateOut;
                if (cpuFunctionComplete) begin
                    doneSeen = 1;
                    cpuRead = 1'b0;
                    cpuWrite = 1'b0;
                end
            end
        end
        if (!aborted) begin
            @(negedge clock);
            if (pD) lineData[pOff] = pData;
            if (pT) lineTag = pTag;
            if (pS) lineState = pSt;
            busAck = 1'b0;
            busGrant = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        totalCnt++;
        if (outBits() !== '0) $display("FAIL reset outputs: got %h want 0", outBits());
        else passCnt++;
        totalCnt++;
        if (cacheStateOut !== 2'd0) $display("FAIL reset state: got %0d want 0", cacheStateOut);
        else passCnt++;
        reset = 1'b1;
        @(negedge clock);
        totalCnt++;
        if (busRequest !== 1'b0) $display("FAIL idle busRequest: got %b want 0", busRequest);
        else passCnt++;
    endtask

    task automatic test_read_hit();
        preload(6'h05, 2'd1, 16'h1230);
        lineData[1] = 16'h1234;
        doAccess(1'b0, 12'h14D, 16'h0000, 0, 1'b1, -1);
        totalCnt++;
        if (!doneSeen || cycles !== 2) $display("FAIL readHit latency: got %0d want 2", cycles);
        else passCnt++;
        totalCnt++;
        if (cpuDataOut !== 16'h1234) $display("FAIL readHit data: got %h want 1234", cpuDataOut);
        else passCnt++;
        totalCnt++;
        if (accessCnt !== 1) $display("FAIL readHit access: got %0d want 1", accessCnt);
        else passCnt++;
        totalCnt++;
        if (reqCycles !== 0) $display("FAIL readHit bus: got %0d want 0", reqCycles);
        else passCnt++;
    endtask

    task automatic test_write_hit_modified();
        preload(6'h05, 2'd2, 16'h2220);
        doAccess(1'b1, 12'h14E, 16'hBEEF, 0, 1'b0, -1);
        totalCnt++;
        if (!doneSeen || cycles !== 2) $display("FAIL writeHit latency: got %0d want 2", cycles);
        else passCnt++;
        totalCnt++;
        if (lineData[2] !== 16'hBEEF) $display("FAIL writeHit data: got %h want beef", lineData[2]);
        else passCnt++;
        totalCnt++;
        if (stateWrVal !== 2'd2) $display("FAIL writeHit state: got %0d want 2", stateWrVal);
        else passCnt++;
        totalCnt++;
        if (reqCycles !== 0) $display("FAIL writeHit bus: got %0d want 0", reqCycles);
        else passCnt++;
    endtask

    task automatic test_read_miss_writeback();
        preload(6'h05, 2'd2, 16'h1100);
        doAccess(1'b0, 12'hA8F, 16'h0000, 0, 1'b0, -1);
        totalCnt++;
        if (!doneSeen || cycles !== 12) $display("FAIL missWb latency: got %0d want 12", cycles);
        else passCnt++;
        totalCnt++;
        if (wbCnt !== 4 || rdCnt !== 4) $display("FAIL missWb words: got wb=%0d rd=%0d want 4/4", wbCnt, rdCnt);
        else passCnt++;
        totalCnt++;
        if (wbAddr[0] !== 12'h14C || wbAddr[3] !== 12'h14F)
            $display("FAIL missWb wbAddr: got %h/%h want 14c/14f", wbAddr[0], wbAddr[3]);
        else passCnt++;
        totalCnt++;
        if (wbData[0] !== 16'h1100 || wbData[3] !== 16'h1103)
            $display("FAIL missWb wbData: got %h/%h want 1100/1103", wbData[0], wbData[3]);
        else passCnt++;
        totalCnt++;
        if (fillAddr[0] !== 12'hA8C || fillAddr[3] !== 12'hA8F)
            $display("FAIL missWb fillAddr: got %h/%h want a8c/a8f", fillAddr[0], fillAddr[3]);
        else passCnt++;
        totalCnt++;
        if (tagWrCnt !== 1 || tagWrState !== 2'd1)
            $display("FAIL missWb tagWrite: got %0d/%0d want 1/1", tagWrCnt, tagWrState);
        else passCnt++;
        totalCnt++;
        if (lineTag !== 6'h2A || lineState !== 2'd1)
            $display("FAIL missWb line: got %h/%0d want 2a/1", lineTag, lineState);
        else passCnt++;
        totalCnt++;
        if (cpuDataOut !== 16'hAA8F || accessCnt !== 1)
            $display("FAIL missWb result: got %h/%0d want aa8f/1", cpuDataOut, accessCnt);
        else passCnt++;
    endtask

    task automatic test_write_hit_shared();
        preload(6'h05, 2'd1, 16'h3300);
        doAccess(1'b1, 12'h14C, 16'h5A5A, 0, 1'b0, -1);
        totalCnt++;
        if (lineState !== 2'd2 || lineData[0] !== 16'h5A5A)
            $display("FAIL writeShared line: got %0d/%h want 2/5a5a", lineState, lineData[0]);
        else passCnt++;
        totalCnt++;
        if (wbCnt !== 0) $display("FAIL writeShared busWrite: got %0d want 0", wbCnt);
        else passCnt++;
`ifdef CPU_CACHE_CONTROLLER_UPGRADE_EN
        totalCnt++;
        if (invCnt !== 1 || rdxCnt !== 0)
            $display("FAIL writeShared upgrade: got inv=%0d rdx=%0d want 1/0", invCnt, rdxCnt);
        else passCnt++;
        totalCnt++;
        if (!doneSeen || cycles !== 3) $display("FAIL writeShared latency: got %0d want 3", cycles);
        else passCnt++;
`else
        totalCnt++;
        if (invCnt !== 0 || rdxCnt !== 4)
            $display("FAIL writeShared rdx: got inv=%0d rdx=%0d want 0/4", invCnt, rdxCnt);
        else passCnt++;
        totalCnt++;
        if (!doneSeen || cycles !== 8) $display("FAIL writeShared latency: got %0d want 8", cycles);
        else passCnt++;
        totalCnt++;
        if (lineData[1] !== 16'hA14D) $display("FAIL writeShared fill: got %h want a14d", lineData[1]);
        else passCnt++;
`endif
    endtask

    task automatic test_ack_stall();
        preload(6'h05, 2'd1, 16'h4400);
        doAccess(1'b0, 12'hF0D, 16'h0000, 3, 1'b0, -1);
        totalCnt++;
        if (!doneSeen || cycles !== 11) $display("FAIL ackStall latency: got %0d want 11", cycles);
        else passCnt++;
        totalCnt++;
        if (rdCnt !== 4 || wbCnt !== 0) $display("FAIL ackStall words: got rd=%0d wb=%0d want 4/0", rdCnt, wbCnt);
        else passCnt++;
        totalCnt++;
        if (cpuDataOut !== 16'hAF0D) $display("FAIL ackStall data: got %h want af0d", cpuDataOut);
        else passCnt++;
    endtask

    task automatic test_reset_mid_fill();
        preload(6'h05, 2'd1, 16'h5500);
        doAccess(1'b0, 12'h44C, 16'h0000, 0, 1'b0, 2);
        totalCnt++;
        if (!aborted) $display("FAIL midReset reached: got %b want 1", aborted);
        else passCnt++;
        #1;
        totalCnt++;
        if (outBits() !== '0) $display("FAIL midReset outputs: got %h want 0", outBits());
        else passCnt++;
        totalCnt++;
        if (cpuDataOut !== 16'h0000) $display("FAIL midReset cpuDataOut: got %h want 0", cpuDataOut);
        else passCnt++;
        cpuRead = 1'b0; busAck = 1'b0; busGrant = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        doAccess(1'b0, 12'h44C, 16'h0000, 0, 1'b0, -1);
        totalCnt++;
        if (!doneSeen || cycles !== 8) $display("FAIL afterReset latency: got %0d want 8", cycles);
        else passCnt++;
        totalCnt++;
        if (rdCnt !== 4 || fillAddr[0] !== 12'h44C || fillAddr[3] !== 12'h44F)
            $display("FAIL afterReset fill: got %0d %h/%h want 4 44c/44f", rdCnt, fillAddr[0], fillAddr[3]);
        else passCnt++;
        totalCnt++;
        if (cpuDataOut !== 16'hA44C) $display("FAIL afterReset data: got %h want a44c", cpuDataOut);
        else passCnt++;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) lineData[i] = '0;
        #1;
        test_reset();
        test_read_hit();
        test_write_hit_modified();
        test_read_miss_writeback();
        test_write_hit_shared();
        test_ack_stall();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/cpu_cache_controller.md
CPU_CACHE_CONTROLLER -- requirements
Module: CpuCacheController

Interface
REQ-001 Parameters SHALL be: TAG_WIDTH default 6, tag bits; INDEX_WIDTH default 4, set index bits; OFFSET_WIDTH default 2, word-in-line bits; DATA_WIDTH default 16, word bits; states are 2 bits (INVALID=0, SHARED=1, MODIFIED=2).
REQ-002 Ports, with A=TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH (name direction width meaning):
  clock  in  1  sole clock, rising edge;
  reset  in  1  asynchronous, active-low;
  cpuAddress  in  A  request address {tag,index,offset};
  cpuDataIn  in  DATA_WIDTH  write data;
  cpuRead, cpuWrite  in  1 each  request strobes, held until cpuFunctionComplete;
  cpuDataOut  out  DATA_WIDTH  read data;
  cpuFunctionComplete  out  1  one-cycle done pulse;
  cacheTag, cacheIndex, cacheOffset  out  TAG/INDEX/OFFSET_WIDTH  cache cpu-port address;
  cacheDataOut  out  DATA_WIDTH  data to cache;
  cacheStateOut  out  2  state to cache;
  cacheWriteTag, cacheWriteData, cacheWriteState  out  1 each  cache write strobes;
  accessEnable  out  1  replacement-algorithm access pulse;
  cacheHit  in  1  collective cpu hit;
  cacheTagIn, cacheDataIn, cacheStateIn  in  TAG/DATA/2  selected (hit or victim) line outputs;
  busRequest  out  1  arbitration request;
  busGrant  in  1  bus owned;
  busRead, busReadExclusive, busWrite, busInvalidate  out  1 each  bus commands;
  busAddress  out  A  word address;
  busDataOut  out  DATA_WIDTH  write-back data;
  busDataIn  in  DATA_WIDTH  fill data;
  busAck  in  1  current word transferred, busDataIn valid.

Function
REQ-003 FSM states SHALL be IDLE, LOOKUP, ARBITRATE, WRITEBACK, FILL, COMPLETE.
REQ-004 IDLE: on cpuRead or cpuWrite, latch address/data/type and go to LOOKUP; both asserted SHALL be treated as write.
REQ-005 Cache address outputs SHALL be driven from the latched address in every non-IDLE state; cacheOffset SHALL come from the word counter during WRITEBACK/FILL.
REQ-006 LOOKUP with cacheHit and (read or cacheStateIn==MODIFIED): pulse accessEnable; on write, assert cacheWriteData and cacheWriteState with MODIFIED; go to COMPLETE.
REQ-007 LOOKUP miss, or write hit in SHARED: go to ARBITRATE with busRequest asserted; busRequest SHALL stay high until leaving WRITEBACK/FILL.
REQ-008 ARBITRATE on busGrant: miss with victim state MODIFIED -> WRITEBACK; otherwise -> FILL (see REQ-016 for upgrade).
REQ-009 WRITEBACK: busWrite high, busAddress={victim tag, index, counter}, busDataOut=cacheDataIn; each busAck increments counter; ack at counter max clears counter, goes to FILL.
REQ-010 FILL: busRead (read request) or busReadExclusive (write request), busAddress={latched tag, index, counter}; each busAck writes busDataIn via cacheWriteData at counter offset; final ack additionally asserts cacheWriteTag and cacheWriteState (SHARED for read, MODIFIED for write), releases bus, returns to LOOKUP.
REQ-011 COMPLETE: pulse cpuFunctionComplete for one cycle, cpuDataOut=cacheDataIn registered in LOOKUP; return to IDLE; CPU SHALL deassert strobes in that cycle.
REQ-012 Latency: hit = done in the 3rd cycle after request sampled; busAck absent SHALL hold state indefinitely; busAck outside WRITEBACK/FILL SHALL be ignored.
REQ-013 Counter SHALL be OFFSET_WIDTH bits, wrapping from max to 0 at end of each transfer.

Reset
REQ-014 reset low SHALL immediately force IDLE, counter 0, and all outputs 0 (cpuDataOut 0, cacheStateOut INVALID), including mid-transfer; bus released; cache contents untouched.
REQ-015 Operation SHALL resume on the first rising edge after reset deasserts.

Configuration
REQ-016 CPU_CACHE_CONTROLLER_UPGRADE_EN defined: write hit in SHARED goes ARBITRATE -> one-cycle busInvalidate with line address on busGrant+busAck, then writes data and MODIFIED state, -> COMPLETE; undefined: such hits are handled as misses (FILL with busReadExclusive, no writeback), busInvalidate tied 0.

Verification
REQ-017 Read hit, line SHARED, data 0x1234 -> cpuFunctionComplete on cycle 3, cpuDataOut=0x1234, one accessEnable pulse, no bus activity.
REQ-018 Write 0xBEEF hit MODIFIED -> cacheWriteData+cacheWriteState(MODIFIED) in LOOKUP, done cycle 3, no bus activity.
REQ-019 Read miss, victim MODIFIED, 4-word line -> 4 busWrite acks with victim words, 4 busRead acks, tag/state SHARED on 4th, then hit completion.
REQ-020 Write hit SHARED -> with macro one busInvalidate then MODIFIED; without, 4 busReadExclusive words, no busWrite.
REQ-021 reset low during FILL word 2 -> all outputs 0 immediately; after release, new read request served from IDLE.
